// File: rtl/insn_parcel_buffer_pkg.sv
// Shared fetch-path types: the 16-bit parcel as written by fetch and the
// assembled instruction handed to decode.
package RafiTypes;

    localparam int PARCEL_WIDTH = 16;
    localparam int INSN_WIDTH   = 2 * PARCEL_WIDTH;

    typedef struct packed {
        logic [31:0]             pc;
        logic [PARCEL_WIDTH-1:0] insn;
        logic                    fault;
        logic                    interrupt_valid;
        logic [3:0]              interrupt_code;
    } parcel_entry_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [INSN_WIDTH-1:0] insn;
        logic                  compressed;
        logic                  fault;
        logic                  interrupt_valid;
        logic [3:0]            interrupt_code;
    } insn_entry_t;

    // A parcel whose two low bits are set opens a 32-bit instruction.
    function automatic logic is_32bit_parcel(input logic [PARCEL_WIDTH-1:0] parcel);
        return parcel[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/insn_parcel_aligner.sv
// Combinational head assembly: decides whether the head parcels form a
// decodable instruction, builds it, and reports how many parcels it consumes.
module insn_parcel_aligner
    import RafiTypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [$clog2(DEPTH+1)-1:0] count_i,
    input  parcel_entry_t              head_parcel_i,
    input  logic [PARCEL_WIDTH-1:0]    next_insn_i,
    input  logic                       next_fault_i,
    output logic                       read_valid_o,
    output insn_entry_t                read_entry_o,
    output logic [1:0]                 pop_len_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic head_is_32;
    logic take_32;

    always_comb begin
        head_is_32 = is_32bit_parcel(head_parcel_i.insn);
        // A faulting head goes out alone so the fault reaches decode even
        // when its partner parcel will never arrive.
        take_32    = head_is_32 && !head_parcel_i.fault;

        read_valid_o = (count_i >= CW'(2))
                    || (count_i == CW'(1) && !head_is_32)
                    || (count_i != '0 && head_parcel_i.fault);

        read_entry_o                 = '0;
        read_entry_o.pc              = head_parcel_i.pc;
        read_entry_o.interrupt_valid = head_parcel_i.interrupt_valid;
        read_entry_o.interrupt_code  = head_parcel_i.interrupt_code;

        if (take_32) begin
            read_entry_o.insn       = {next_insn_i, head_parcel_i.insn};
            read_entry_o.compressed = 1'b0;
            read_entry_o.fault      = head_parcel_i.fault | next_fault_i;
            pop_len_o               = 2'd2;
        end else begin
            read_entry_o.insn       = {{PARCEL_WIDTH{1'b0}}, head_parcel_i.insn};
            read_entry_o.compressed = !head_is_32;
            read_entry_o.fault      = head_parcel_i.fault;
            pop_len_o               = 2'd1;
        end
    end

endmodule

// File: rtl/insn_parcel_buffer.sv
// Parcel FIFO between fetch and decode; writes visible one cycle later, reads combinational from registers.
// Backpressure: writable_entry_count (registered) gates fetch; over-capacity writes are dropped whole.
// Optional saturating perf counters under RAFI_INSN_BUFFER_PERF_COUNTER_EN.
module insn_parcel_buffer
    import RafiTypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       write_low,
    input  logic                       write_high,
    input  parcel_entry_t              write_entry_low,
    input  parcel_entry_t              write_entry_high,
    output logic [$clog2(DEPTH+1)-1:0] writable_entry_count,
    output logic                       read_valid,
    input  logic                       read_ready,
    output insn_entry_t                read_entry
`ifdef RAFI_INSN_BUFFER_PERF_COUNTER_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_empty_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    parcel_entry_t   parcel_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [PW-1:0]   head_next;
    logic [PW-1:0]   tail_next;
    logic [1:0]      pop_len;
    logic [1:0]      pop_cnt;
    logic [1:0]      wr_cnt;
    logic [1:0]      wr_eff;
    logic [CW:0]     free_after_pop;
    logic            wr_ok;

    assign head_next = head_q + PW'(1);
    assign tail_next = tail_q + PW'(1);

    insn_parcel_aligner #(
        .DEPTH (DEPTH)
    ) u_aligner (
        .count_i       (count_q),
        .head_parcel_i (parcel_q[head_q]),
        .next_insn_i   (parcel_q[head_next].insn),
        .next_fault_i  (parcel_q[head_next].fault),
        .read_valid_o  (read_valid),
        .read_entry_o  (read_entry),
        .pop_len_o     (pop_len)
    );

    assign writable_entry_count = CW'(DEPTH) - count_q;

    always_comb begin
        pop_cnt = (read_valid && read_ready) ? pop_len : 2'd0;
        wr_cnt  = {1'b0, write_low} + {1'b0, write_high};
        // Space freed by this cycle's pop counts, so a full buffer can
        // still take a pair while decode drains a 32-bit instruction.
        free_after_pop = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop_cnt);
        wr_ok   = (CW+1)'(wr_cnt) <= free_after_pop;
        wr_eff  = wr_ok ? wr_cnt : 2'd0;

        head_d  = head_q + PW'(pop_cnt);
        tail_d  = tail_q + PW'(wr_eff);
        count_d = count_q + CW'(wr_eff) - CW'(pop_cnt);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            if (write_low) begin
                parcel_q[tail_q] <= write_entry_low;
            end
            if (write_high) begin
                parcel_q[write_low ? tail_next : tail_q] <= write_entry_high;
            end
        end
    end

`ifdef RAFI_INSN_BUFFER_PERF_COUNTER_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (count_q == CW'(DEPTH) && perf_full_q != '1) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if (count_q == '0 && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_insn_parcel_buffer.sv
// Bench for insn_parcel_buffer: vector table for single transactions, hand
// sequences for wrap-around, overflow, flush and mid-run reset.
module tb_insn_parcel_buffer;
    import RafiTypes::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          write_low;
    logic          write_high;
    parcel_entry_t write_entry_low;
    parcel_entry_t write_entry_high;
    logic [3:0]    writable_entry_count;
    logic          read_valid;
    logic          read_ready;
    insn_entry_t   read_entry;
`ifdef RAFI_INSN_BUFFER_PERF_COUNTER_EN
    logic [31:0]   perf_full_cycles;
    logic [31:0]   perf_empty_cycles;
`endif

    int checks = 0;
    int errors = 0;
    insn_entry_t sb_q[$];

    always #5 clk = ~clk;

    insn_parcel_buffer #(.DEPTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .write_low            (write_low),
        .write_high           (write_high),
        .write_entry_low      (write_entry_low),
        .write_entry_high     (write_entry_high),
        .writable_entry_count (writable_entry_count),
        .read_valid           (read_valid),
        .read_ready           (read_ready),
        .read_entry           (read_entry)
`ifdef RAFI_INSN_BUFFER_PERF_COUNTER_EN
        ,
        .perf_full_cycles     (perf_full_cycles),
        .perf_empty_cycles    (perf_empty_cycles)
`endif
    );

    typedef struct {
        logic        wl;
        logic        wh;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        lf;
        logic        hf;
        logic [31:0] pc;
        logic        exp_vld;
        logic [31:0] exp_insn;
        logic        exp_cmp;
        logic        exp_flt;
        logic [31:0] exp_pc;
        logic [3:0]  exp_wec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush            = 1'b0;
        write_low        = 1'b0;
        write_high       = 1'b0;
        read_ready       = 1'b0;
        write_entry_low  = '0;
        write_entry_high = '0;
    endtask

    function automatic parcel_entry_t mk(input logic [15:0] insn, input logic [31:0] pc,
                                         input logic flt, input logic iv, input logic [3:0] ic);
        parcel_entry_t p;
        p.pc              = pc;
        p.insn            = insn;
        p.fault           = flt;
        p.interrupt_valid = iv;
        p.interrupt_code  = ic;
        return p;
    endfunction

    function automatic insn_entry_t mk_exp(input logic [31:0] pc, input logic [31:0] insn,
                                           input logic cmp, input logic flt,
                                           input logic iv, input logic [3:0] ic);
        insn_entry_t e;
        e.pc              = pc;
        e.insn            = insn;
        e.compressed      = cmp;
        e.fault           = flt;
        e.interrupt_valid = iv;
        e.interrupt_code  = ic;
        return e;
    endfunction

    // Compare the presented head instruction with the oldest expectation.
    task automatic check_head(input string name);
        insn_entry_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got read attempt required a queued expectation", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, ".vld"},  32'(read_valid), 32'd1);
        chk({name, ".insn"}, read_entry.insn, e.insn);
        chk({name, ".pc"},   read_entry.pc,   e.pc);
        chk({name, ".cmp"},  32'(read_entry.compressed), 32'(e.compressed));
        chk({name, ".flt"},  32'(read_entry.fault),      32'(e.fault));
        chk({name, ".iv"},   32'(read_entry.interrupt_valid), 32'(e.interrupt_valid));
        chk({name, ".ic"},   32'(read_entry.interrupt_code),  32'(e.interrupt_code));
    endtask

    task automatic write_pair(input logic [15:0] lo, input logic [15:0] hi, input logic [31:0] pc);
        write_low        = 1'b1;
        write_high       = 1'b1;
        write_entry_low  = mk(lo, pc, 1'b0, 1'b0, 4'h0);
        write_entry_high = mk(hi, pc + 32'd2, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'h0413, 16'h0000, 1'b0, 1'b0, 32'h100,
                    1'b1, 32'h00000413, 1'b0, 1'b0, 32'h100, 4'd8};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h4501, 1'b0, 1'b0, 32'h202,
                    1'b1, 32'h00004501, 1'b1, 1'b0, 32'h202, 4'd8};
        vecs[2] = '{1'b1, 1'b0, 16'h0513, 16'h0000, 1'b0, 1'b0, 32'h300,
                    1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd7};
        vecs[3] = '{1'b1, 1'b0, 16'h0513, 16'h0000, 1'b1, 1'b0, 32'h400,
                    1'b1, 32'h00000513, 1'b0, 1'b1, 32'h400, 4'd8};
        vecs[4] = '{1'b1, 1'b1, 16'h4501, 16'h8082, 1'b0, 1'b0, 32'h500,
                    1'b1, 32'h00004501, 1'b1, 1'b0, 32'h500, 4'd7};
        vecs[5] = '{1'b1, 1'b1, 16'h1237, 16'hABCD, 1'b0, 1'b1, 32'h600,
                    1'b1, 32'hABCD1237, 1'b0, 1'b1, 32'h600, 4'd8};
        vecs[6] = '{1'b1, 1'b1, 16'h0001, 16'h0413, 1'b1, 1'b0, 32'h700,
                    1'b1, 32'h00000001, 1'b1, 1'b1, 32'h700, 4'd7};
        vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 32'h800,
                    1'b1, 32'h0000FFFF, 1'b0, 1'b0, 32'h800, 4'd8};

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.wec", 32'(writable_entry_count), 32'd8);
        chk("reset.vld", 32'(read_valid), 32'd0);
        tick();
        chk("idle.vld", 32'(read_valid), 32'd0);

        // Vector table: one transaction from an empty buffer each.
        for (int i = 0; i < 8; i++) begin
            logic        iv_lo, iv_hi;
            logic [3:0]  ic_lo, ic_hi;
            int          nwr;
            idle();
            flush = 1'b1;
            tick();
            idle();
            iv_lo = 1'(i);
            iv_hi = ~iv_lo;
            ic_lo = 4'(i + 1);
            ic_hi = 4'(15 - i);
            write_low        = vecs[i].wl;
            write_high       = vecs[i].wh;
            write_entry_low  = mk(vecs[i].lo, vecs[i].pc, vecs[i].lf, iv_lo, ic_lo);
            write_entry_high = mk(vecs[i].hi, vecs[i].wl ? vecs[i].pc + 32'd2 : vecs[i].pc,
                                  vecs[i].hf, iv_hi, ic_hi);
            nwr = int'(vecs[i].wl) + int'(vecs[i].wh);
            #1;
            chk($sformatf("vec%0d.nobypass", i), 32'(read_valid), 32'd0);
            if (vecs[i].exp_vld)
                sb_q.push_back(mk_exp(vecs[i].exp_pc, vecs[i].exp_insn, vecs[i].exp_cmp,
                                      vecs[i].exp_flt,
                                      vecs[i].wl ? iv_lo : iv_hi, vecs[i].wl ? ic_lo : ic_hi));
            tick();
            idle();
            chk($sformatf("vec%0d.wec_wr", i), 32'(writable_entry_count), 32'(8 - nwr));
            if (vecs[i].exp_vld)
                check_head($sformatf("vec%0d", i));
            else
                chk($sformatf("vec%0d.vld", i), 32'(read_valid), 32'd0);
            read_ready = 1'b1;
            tick();
            idle();
            chk($sformatf("vec%0d.wec_rd", i), 32'(writable_entry_count), 32'(vecs[i].exp_wec));
        end

        // Walk head/tail to index 7 with concurrent single writes and pops.
        flush = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 7; k++) begin
            write_low       = 1'b1;
            write_entry_low = mk(16'h0001, 32'h1000 + 32'(2 * k), 1'b0, 1'b0, 4'h0);
            read_ready      = 1'b1;
            tick();
        end
        idle();
        read_ready = 1'b1;
        tick();
        idle();
        chk("walk.vld", 32'(read_valid), 32'd0);
        chk("walk.wec", 32'(writable_entry_count), 32'd8);

        // Fill to capacity with four 32-bit instructions.
        for (int k = 0; k < 4; k++) begin
            write_pair(16'h0013 + 16'(k << 8), 16'h00A0 + 16'(k), 32'h2000 + 32'(4 * k));
            sb_q.push_back(mk_exp(32'h2000 + 32'(4 * k),
                                  {16'h00A0 + 16'(k), 16'h0013 + 16'(k << 8)},
                                  1'b0, 1'b0, 1'b0, 4'h0));
            tick();
        end
        idle();
        chk("full.wec", 32'(writable_entry_count), 32'd0);

        // Write into a full buffer with no pop is dropped.
        write_pair(16'hDEAD, 16'hBEEF, 32'h9999);
        tick();
        idle();
        chk("drop.wec", 32'(writable_entry_count), 32'd0);
        chk("drop.insn", read_entry.insn, 32'h00A00013);

        // Pop one instruction and write a pair in the same cycle at full.
        check_head("wrap0");
        write_pair(16'h0013 + 16'(4 << 8), 16'h00A4, 32'h2010);
        sb_q.push_back(mk_exp(32'h2010, 32'h00A40413, 1'b0, 1'b0, 1'b0, 4'h0));
        read_ready = 1'b1;
        tick();
        idle();
        chk("wrap.wec", 32'(writable_entry_count), 32'd0);
        for (int k = 1; k < 5; k++) begin
            check_head($sformatf("wrap%0d", k));
            read_ready = 1'b1;
            tick();
            idle();
        end
        chk("drain.wec", 32'(writable_entry_count), 32'd8);
        chk("drain.vld", 32'(read_valid), 32'd0);
        chk("drain.sb", 32'(sb_q.size()), 32'd0);

        // Flush together with a write discards everything.
        for (int k = 0; k < 3; k++) begin
            write_pair(16'h0001, 16'h0002, 32'h3000 + 32'(4 * k));
            tick();
        end
        idle();
        chk("prefl.wec", 32'(writable_entry_count), 32'd2);
        flush = 1'b1;
        write_pair(16'h0413, 16'h0000, 32'h3100);
        tick();
        idle();
        chk("flush.wec", 32'(writable_entry_count), 32'd8);
        chk("flush.vld", 32'(read_valid), 32'd0);
        write_pair(16'h0093, 16'h1234, 32'h3200);
        sb_q.push_back(mk_exp(32'h3200, 32'h12340093, 1'b0, 1'b0, 1'b0, 4'h0));
        tick();
        idle();
        check_head("postfl");
        read_ready = 1'b1;
        tick();
        idle();
        chk("postfl.wec", 32'(writable_entry_count), 32'd8);

        // Reset in the middle of traffic wins over a concurrent write.
        write_pair(16'h0001, 16'h0002, 32'h4000);
        tick();
        rst = 1'b1;
        write_pair(16'h0003, 16'h0004, 32'h4004);
        tick();
        rst = 1'b0;
        idle();
        chk("midrst.wec", 32'(writable_entry_count), 32'd8);
        chk("midrst.vld", 32'(read_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
